// File: rtl/hsst2ad_pkg.sv
// Shared types and constants for the hsst2ad read-side controller.
// The almost-empty level must track the FIFO configuration it is paired with.
package hsst2ad_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int SKID_DEPTH       = 2;
  localparam int ALMOST_EMPTY_LVL = 4;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } state_e;

endpackage

// File: rtl/hsst2ad_skid_buf.sv
// Two-entry {last,data} buffer that absorbs the FIFO read latency.
// Head entry is always slot 0; push and pop may happen in the same cycle.
module hsst2ad_skid_buf
  import hsst2ad_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic                  head_last_o,
  output logic [1:0]            occ_o
);

  logic [DATA_WIDTH:0] e0_q, e0_d;
  logic [DATA_WIDTH:0] e1_q, e1_d;
  logic [1:0]          occ_q, occ_d;
  logic [DATA_WIDTH:0] entry;

  assign entry = {push_last_i, push_data_i};

  // pop is only ever requested with a non-empty head, and the caller never pushes into a full buffer
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    if (push_i && pop_i) begin
      if (occ_q == 2'd2) begin
        e0_d = e1_q;
        e1_d = entry;
      end else begin
        e0_d = entry;
      end
    end else if (push_i) begin
      if (occ_q == 2'd0) begin
        e0_d = entry;
      end else begin
        e1_d = entry;
      end
      occ_d = occ_q + 2'd1;
    end else if (pop_i) begin
      e0_d  = e1_q;
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign head_data_o = e0_q[DATA_WIDTH-1:0];
  assign head_last_o = e0_q[DATA_WIDTH];
  assign occ_o       = occ_q;

endmodule

// File: rtl/hsst2ad_rd_ctrl.sv
// Read-side burst scheduler for the hsst2ad FIFO: issues reads, skids the
// 1-cycle read latency and presents valid/ready bursts delimited by m_last.
module hsst2ad_rd_ctrl
  import hsst2ad_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int BURST_W     = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  ctrl_en,
  input  logic [BURST_W-1:0]    cfg_burst_len,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic                  fifo_almost_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_W-1:0]      burst_cnt
);

  localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT_CYC - 1);

  state_e              state_q;
  logic [BURST_W-1:0]  beats_left_q;
  logic [IDLE_W-1:0]   idle_cnt_q;
  logic                pend_q;
  logic                pend_last_q;
  logic [CNT_W-1:0]    burst_cnt_q;

  logic [1:0]          occ;
  logic [DATA_WIDTH-1:0] head_data;
  logic                head_last;
  logic                pop;
  logic                rd_en;
  logic                start_normal;
  logic                start_flush;
  logic                last_read;

  // Reads in flight plus buffered beats may never exceed the skid depth,
  // and the FIFO is never read while empty.
  assign rd_en = (state_q == BURST) && !fifo_rd_empty &&
                 (({1'b0, occ} + {2'b00, pend_q}) < 3'(SKID_DEPTH));

  assign last_read    = rd_en && (beats_left_q == BURST_W'(1));
  assign pop          = m_valid && m_ready;
  assign start_normal = ctrl_en && !fifo_almost_empty;
  assign start_flush  = ctrl_en && !fifo_rd_empty && (idle_cnt_q == IDLE_LIM);

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      idle_cnt_q   <= '0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      burst_cnt_q  <= '0;
    end else begin
      pend_q      <= rd_en;
      pend_last_q <= last_read;
      case (state_q)
        IDLE: begin
          if (start_normal) begin
            state_q      <= BURST;
            beats_left_q <= (cfg_burst_len == '0) ? BURST_W'(1) : cfg_burst_len;
            idle_cnt_q   <= '0;
          end else if (start_flush) begin
            state_q      <= BURST;
            beats_left_q <= BURST_W'(1);
            idle_cnt_q   <= '0;
          end else if (!fifo_rd_empty) begin
            // Saturate so a disabled controller keeps the flush condition armed
            if (idle_cnt_q != IDLE_LIM) begin
              idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
            end
          end else begin
            idle_cnt_q <= '0;
          end
        end
        BURST: begin
          if (rd_en) begin
            beats_left_q <= beats_left_q - BURST_W'(1);
            if (last_read) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && head_last) begin
            burst_cnt_q <= burst_cnt_q + CNT_W'(1);
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  hsst2ad_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i       (rd_clk),
    .rst_i       (rd_rst),
    .push_i      (pend_q),
    .push_data_i (fifo_rd_data),
    .push_last_i (pend_last_q),
    .pop_i       (pop),
    .head_data_o (head_data),
    .head_last_o (head_last),
    .occ_o       (occ)
  );

  assign fifo_rd_en = rd_en;
  assign m_valid    = (occ != 2'd0);
  assign m_data     = head_data;
  assign m_last     = head_last && m_valid;
  assign busy       = (state_q != IDLE) || (occ != 2'd0);
  assign burst_cnt  = burst_cnt_q;

endmodule

// File: tb/tb_hsst2ad_rd_ctrl.sv
// Directed bench for hsst2ad_rd_ctrl: a behavioural FIFO feeds the DUT,
// a negedge monitor logs handshakes and protocol violations.
module tb_hsst2ad_rd_ctrl;
  import hsst2ad_pkg::*;

  localparam int TMO = 16;

  logic        rd_clk;
  logic        rd_rst;
  logic        ctrl_en;
  logic [7:0]  cfg_burst_len;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_empty;
  logic        fifo_almost_empty;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic        busy;
  logic [15:0] burst_cnt;

  hsst2ad_rd_ctrl #(
    .DATA_WIDTH  (8),
    .BURST_W     (8),
    .TIMEOUT_CYC (TMO),
    .CNT_W       (16)
  ) dut (
    .rd_clk            (rd_clk),
    .rd_rst            (rd_rst),
    .ctrl_en           (ctrl_en),
    .cfg_burst_len     (cfg_burst_len),
    .fifo_rd_en        (fifo_rd_en),
    .fifo_rd_data      (fifo_rd_data),
    .fifo_rd_empty     (fifo_rd_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_data            (m_data),
    .m_last            (m_last),
    .busy              (busy),
    .burst_cnt         (burst_cnt)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // Behavioural FIFO: mem/wptr owned by the stimulus, rptr/read data by this block
  logic [7:0] mem [0:255];
  int wptr = 0;
  int rptr = 0;
  int fifoCount;
  assign fifoCount         = wptr - rptr;
  assign fifo_rd_empty     = (fifoCount == 0);
  assign fifo_almost_empty = (fifoCount <= ALMOST_EMPTY_LVL);

  always @(posedge rd_clk) begin
    if (rd_rst) begin
      rptr         <= wptr;
      fifo_rd_data <= 8'h00;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= mem[8'(rptr)];
      rptr         <= rptr + 1;
    end
  end

  int         popCnt = 0;
  int         rdCnt = 0;
  int         emptyViol = 0;
  int         guardViol = 0;
  int         stableViol = 0;
  logic [7:0] logData [0:63];
  logic       logLast [0:63];
  logic       prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;
  logic       prevLast = 1'b0;

  // Reads outstanding at the start of a cycle equal occ+pend inside the DUT
  always @(negedge rd_clk) begin
    if (rd_rst) begin
      popCnt    <= 0;
      rdCnt     <= 0;
      prevStall <= 1'b0;
    end else begin
      if (fifo_rd_en && fifo_rd_empty) emptyViol <= emptyViol + 1;
      if (fifo_rd_en && (rdCnt - popCnt) >= SKID_DEPTH) guardViol <= guardViol + 1;
      if (prevStall && (!m_valid || m_data != prevData || m_last != prevLast))
        stableViol <= stableViol + 1;
      if (fifo_rd_en) rdCnt <= rdCnt + 1;
      if (m_valid && m_ready && popCnt < 64) begin
        logData[popCnt] <= m_data;
        logLast[popCnt] <= m_last;
        popCnt          <= popCnt + 1;
      end
      prevStall <= m_valid && !m_ready;
      prevData  <= m_data;
      prevLast  <= m_last;
    end
  end

  int checksTotal = 0;
  int checksPassed = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checksTotal++;
    if (act == exp) checksPassed++;
    else $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic doReset();
    rd_rst  = 1'b1;
    ctrl_en = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge rd_clk);
    #1 rd_rst = 1'b0;
  endtask

  task automatic loadFifo(input int n, input int firstVal);
    for (int i = 0; i < n; i++) mem[8'(wptr + i)] = 8'(firstVal + i);
    wptr = wptr + n;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  function automatic int lastMask(input int n);
    int m = 0;
    for (int i = 0; i < n && i < 32; i++) if (logLast[i]) m = m | (1 << i);
    return m;
  endfunction

  function automatic int orderErrors(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) if (logData[i] != 8'(i)) bad++;
    return bad;
  endfunction

  // Wait (after an edge) until n beats have handshaken and the DUT is idle
  task automatic waitDone(input string name, input int n, input bit toggle);
    int cyc = 0;
    while (!(popCnt == n && !busy) && cyc < 3000) begin
      @(posedge rd_clk);
      #1;
      if (toggle) m_ready = ~m_ready;
      cyc++;
    end
    if (cyc >= 3000) checkOutput({name, "_timeout"}, cyc, 0);
    m_ready = 1'b1;
    waitCycles(3);
  endtask

  typedef struct {
    int cfgLen;
    int nBytes;
    bit toggle;
    int expMask;
    int expBursts;
  } vec_t;

  vec_t vecs [0:5];

  task automatic applyStimulus(input int idx);
    string nm;
    nm = $sformatf("v%0d", idx);
    doReset();
    cfg_burst_len = 8'(vecs[idx].cfgLen);
    loadFifo(vecs[idx].nBytes, 0);
    ctrl_en = 1'b1;
    m_ready = 1'b1;
    waitDone(nm, vecs[idx].nBytes, vecs[idx].toggle);
    checkOutput({nm, "_beats"}, popCnt, vecs[idx].nBytes);
    checkOutput({nm, "_order"}, orderErrors(vecs[idx].nBytes), 0);
    checkOutput({nm, "_lastmask"}, lastMask(vecs[idx].nBytes), vecs[idx].expMask);
    checkOutput({nm, "_burst_cnt"}, int'(burst_cnt), vecs[idx].expBursts);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, %0d/%0d checks passed so far",
             checksPassed, checksTotal);
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int quiet;
    int lat;
    rd_rst = 1'b1;
    ctrl_en = 1'b0;
    m_ready = 1'b0;
    cfg_burst_len = 8'd0;

    // Expected last-beat masks: normal bursts while >4 bytes remain, then singles
    vecs[0] = '{cfgLen: 8, nBytes: 20, toggle: 1'b0, expMask: 32'h000F8080, expBursts: 6};
    vecs[1] = '{cfgLen: 3, nBytes: 3,  toggle: 1'b0, expMask: 32'h00000007, expBursts: 3};
    vecs[2] = '{cfgLen: 4, nBytes: 10, toggle: 1'b1, expMask: 32'h00000388, expBursts: 4};
    vecs[3] = '{cfgLen: 0, nBytes: 6,  toggle: 1'b0, expMask: 32'h0000003F, expBursts: 6};
    vecs[4] = '{cfgLen: 5, nBytes: 9,  toggle: 1'b0, expMask: 32'h000001F0, expBursts: 5};
    vecs[5] = '{cfgLen: 2, nBytes: 7,  toggle: 1'b1, expMask: 32'h0000007A, expBursts: 5};

    doReset();
    checkOutput("rst_fifo_rd_en", int'(fifo_rd_en), 0);
    checkOutput("rst_m_valid", int'(m_valid), 0);
    checkOutput("rst_m_data", int'(m_data), 0);
    checkOutput("rst_m_last", int'(m_last), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_burst_cnt", int'(burst_cnt), 0);

    for (int i = 0; i < 6; i++) applyStimulus(i);

    // Flush timeout and read-to-valid latency
    doReset();
    cfg_burst_len = 8'd8;
    loadFifo(3, 0);
    ctrl_en = 1'b1;
    m_ready = 1'b1;
    quiet = 0;
    while (quiet < 100) begin
      @(negedge rd_clk);
      if (fifo_rd_en) break;
      quiet++;
    end
    checkOutput("tmo_quiet_cycles", quiet, TMO);
    lat = 0;
    while (lat < 10) begin
      @(negedge rd_clk);
      lat++;
      if (m_valid) break;
    end
    checkOutput("tmo_valid_latency", lat, 2);
    checkOutput("tmo_first_last", int'(m_last), 1);
    waitDone("tmo", 3, 1'b0);
    checkOutput("tmo_lastmask", lastMask(3), 7);

    // Burst stalls on an empty FIFO and resumes when data arrives
    doReset();
    cfg_burst_len = 8'd6;
    loadFifo(5, 0);
    ctrl_en = 1'b1;
    m_ready = 1'b1;
    quiet = 0;
    while (rdCnt < 5 && quiet < 100) begin
      @(posedge rd_clk);
      #1;
      quiet++;
    end
    waitCycles(10);
    checkOutput("stall_rd_cnt", rdCnt, 5);
    checkOutput("stall_popped", popCnt, 5);
    checkOutput("stall_busy", int'(busy), 1);
    checkOutput("stall_lastmask", lastMask(5), 0);
    loadFifo(3, 5);
    waitDone("stall", 8, 1'b0);
    checkOutput("stall_beat6_last", int'(logLast[5]), 1);
    checkOutput("stall_order", orderErrors(8), 0);
    checkOutput("stall_lastmask_full", lastMask(8), 32'hE0);
    checkOutput("stall_burst_cnt", int'(burst_cnt), 3);

    // Reset with the skid buffer full
    doReset();
    cfg_burst_len = 8'd8;
    loadFifo(20, 0);
    ctrl_en = 1'b1;
    m_ready = 1'b1;
    quiet = 0;
    while (burst_cnt != 16'd1 && quiet < 200) begin
      @(posedge rd_clk);
      #1;
      quiet++;
    end
    m_ready = 1'b0;
    waitCycles(8);
    checkOutput("mid_inflight", rdCnt - popCnt, 2);
    checkOutput("mid_m_valid", int'(m_valid), 1);
    checkOutput("mid_head_data", int'(m_data), 8);
    rd_rst = 1'b1;
    @(posedge rd_clk);
    #1;
    checkOutput("mid_rst_m_valid", int'(m_valid), 0);
    checkOutput("mid_rst_rd_en", int'(fifo_rd_en), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_burst_cnt", int'(burst_cnt), 0);
    checkOutput("mid_rst_m_data", int'(m_data), 0);
    rd_rst = 1'b0;
    m_ready = 1'b1;
    waitCycles(30);
    checkOutput("mid_post_rd_cnt", rdCnt, 0);
    checkOutput("mid_post_popped", popCnt, 0);

    // ctrl_en dropped during a 1-beat burst
    doReset();
    cfg_burst_len = 8'd0;
    loadFifo(20, 0);
    ctrl_en = 1'b1;
    m_ready = 1'b1;
    quiet = 0;
    while (quiet < 100) begin
      @(negedge rd_clk);
      if (fifo_rd_en) break;
      quiet++;
    end
    ctrl_en = 1'b0;
    waitCycles(60);
    checkOutput("dis_rd_cnt", rdCnt, 1);
    checkOutput("dis_popped", popCnt, 1);
    checkOutput("dis_last", int'(logLast[0]), 1);
    checkOutput("dis_data", int'(logData[0]), 0);
    checkOutput("dis_burst_cnt", int'(burst_cnt), 1);
    checkOutput("dis_busy", int'(busy), 0);

    checkOutput("viol_rd_while_empty", emptyViol, 0);
    checkOutput("viol_skid_guard", guardViol, 0);
    checkOutput("viol_stall_stable", stableViol, 0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
